// File: rtl/hdr_pkg.sv
// Shared definitions for the header parser and the MAC lookup stage:
// EtherType constant, header-vector field offsets, flag bit indices,
// the parser FSM state encoding and a helper that packs the vector.
package hdr_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  localparam int HV_W       = 200;
  localparam int HV_ID_LSB  = 192;
  localparam int HV_DMAC_LSB = 144;
  localparam int HV_SMAC_LSB = 96;
  localparam int HV_ETYPE_LSB = 80;
  localparam int HV_SRC_LSB = 48;
  localparam int HV_DST_LSB = 16;
  localparam int HV_PROTO_LSB = 8;
  localparam int HV_FLAGS_LSB = 0;

  localparam int FLAG_IPV4  = 0;
  localparam int FLAG_TRUNC = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W1   = 3'd1,
    ST_W2   = 3'd2,
    ST_W3   = 3'd3,
    ST_W4   = 3'd4,
    ST_SKIP = 3'd5
  } hdr_state_t;

  // Field order matches the vector layout from dmac down to protocol.
  typedef struct packed {
    logic [47:0] dmac;
    logic [47:0] smac;
    logic [15:0] etype;
    logic [31:0] src;
    logic [31:0] dst;
    logic [7:0]  proto;
  } hdr_fields_t;

  function automatic logic [HV_W-1:0] pack_hdr(input logic [7:0] id,
                                               input hdr_fields_t f,
                                               input logic [7:0] flags);
    return {id, f.dmac, f.smac, f.etype, f.src, f.dst, f.proto, flags};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Next count: step on inc unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
  end

  // Count register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/header_parser.sv
// Passive L2/IPv4 header extractor on a 64-bit framed stream. Captures
// MACs, EtherType and IPv4 src/dst/protocol and emits one 200-bit header
// vector pulse per accepted packet, tagged with a wrapping 8-bit packet ID.
// Optional statistics outputs are built when HDR_PARSER_STATS_EN is defined.
module header_parser
  import hdr_pkg::*;
#(
  parameter int ID_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic [63:0]   in_data,
  output logic          headerVector_valid,
  output logic [199:0]  headerVector
`ifdef HDR_PARSER_STATS_EN
  ,
  output logic [15:0]   stat_pkt_cnt,
  output logic [15:0]   stat_err_cnt
`endif
);

  hdr_state_t    state_q, state_d;
  hdr_fields_t   fld_q, fld_d;
  logic [ID_W-1:0] pkt_id_q, pkt_id_d;
  logic [199:0]  hv_q, hv_d;
  logic          hv_valid_q, hv_valid_d;
  logic          emit;
  logic          flag_ipv4;
  logic          flag_trunc;
  logic          err_evt;

  // FSM next state, field capture and emit decision for the current beat.
  always_comb begin
    state_d    = state_q;
    fld_d      = fld_q;
    emit       = 1'b0;
    flag_ipv4  = 1'b0;
    flag_trunc = 1'b0;
    err_evt    = 1'b0;
    if (in_valid) begin
      if (in_sop) begin
        // A sop always starts a fresh capture; an unfinished packet is dropped.
        if (state_q inside {ST_W1, ST_W2, ST_W3, ST_W4}) err_evt = 1'b1;
        fld_d             = '0;
        fld_d.dmac        = in_data[63:16];
        fld_d.smac[47:32] = in_data[15:0];
        if (in_eop) begin
          state_d = ST_IDLE;
          err_evt = 1'b1;
        end else begin
          state_d = ST_W1;
        end
      end else begin
        unique case (state_q)
          ST_W1: begin
            fld_d.smac[31:0] = in_data[63:32];
            fld_d.etype      = in_data[31:16];
            if (in_data[31:16] != ETHERTYPE_IPV4) begin
              emit    = 1'b1;
              state_d = in_eop ? ST_IDLE : ST_SKIP;
            end else if (in_eop) begin
              emit       = 1'b1;
              flag_ipv4  = 1'b1;
              flag_trunc = 1'b1;
              err_evt    = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_W2;
            end
          end
          ST_W2, ST_W3: begin
            if (state_q == ST_W2) begin
              fld_d.proto = in_data[7:0];
            end else begin
              fld_d.src        = in_data[47:16];
              fld_d.dst[31:16] = in_data[15:0];
            end
            if (in_eop) begin
              emit       = 1'b1;
              flag_ipv4  = 1'b1;
              flag_trunc = 1'b1;
              err_evt    = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              state_d = (state_q == ST_W2) ? ST_W3 : ST_W4;
            end
          end
          ST_W4: begin
            fld_d.dst[15:0] = in_data[63:48];
            emit      = 1'b1;
            flag_ipv4 = 1'b1;
            state_d   = in_eop ? ST_IDLE : ST_SKIP;
          end
          ST_SKIP: begin
            if (in_eop) state_d = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Output vector and packet-ID update on emit; vector holds between emits.
  always_comb begin
    hv_d       = hv_q;
    hv_valid_d = emit;
    pkt_id_d   = pkt_id_q;
    if (emit) begin
      hv_d     = pack_hdr(pkt_id_q, fld_d, {6'b0, flag_trunc, flag_ipv4});
      pkt_id_d = pkt_id_q + 1'b1;
    end
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fld_q      <= '0;
      pkt_id_q   <= '0;
      hv_q       <= '0;
      hv_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fld_q      <= fld_d;
      pkt_id_q   <= pkt_id_d;
      hv_q       <= hv_d;
      hv_valid_q <= hv_valid_d;
    end
  end

  assign headerVector_valid = hv_valid_q;
  assign headerVector       = hv_q;

`ifdef HDR_PARSER_STATS_EN
  sat_counter u_pkt_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (emit),
    .count (stat_pkt_cnt)
  );

  sat_counter u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_evt),
    .count (stat_err_cnt)
  );
`else
  logic unused_err_evt;
  assign unused_err_evt = err_evt;
`endif

endmodule
